// File: rtl/spi_fpga_slave_sync_pkg.sv
// Shared types and helpers for the oversampled SPI slave.
package spi_fpga_slave_sync_pkg;

  // Frame state: waiting for chip select, or inside a frame.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // SPI mode encoding {CPOL, CPHA}.
  typedef enum logic [1:0] {
    MODE_0 = 2'b00,
    MODE_1 = 2'b01,
    MODE_2 = 2'b10,
    MODE_3 = 2'b11
  } spi_mode_t;

  localparam int MODE_CPOL_BIT = 1;
  localparam int MODE_CPHA_BIT = 0;

  // Width of a bit counter that counts 0 .. pack_length-1.
  function automatic int cnt_width(input int pack_length);
    return (pack_length <= 2) ? 1 : $clog2(pack_length);
  endfunction

endpackage

// File: rtl/spi_fpga_slave_sync_edge.sv
// N-stage synchroniser for one asynchronous bus line, plus a one-cycle
// pulse whenever the synchronised level changes.
module spi_fpga_slave_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic srst,
  input  logic din,
  output logic level,
  output logic toggle
);

  logic [STAGES-1:0] sync_reg;
  logic              prev_reg;

  // Shift the raw input through the synchroniser and remember the last level.
  always_ff @(posedge clk) begin
    if (srst) begin
      sync_reg <= {STAGES{RESET_VAL}};
      prev_reg <= RESET_VAL;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], din};
      prev_reg <= sync_reg[STAGES-1];
    end
  end

  assign level  = sync_reg[STAGES-1];
  assign toggle = sync_reg[STAGES-1] ^ prev_reg;

endmodule

// File: rtl/spi_fpga_slave_sync.sv
// SPI slave, run-time selectable CPOL/CPHA, bus oversampled in IN_CLK.
// Multi-word frames per CS assertion, one-word TX holding register.
module spi_fpga_slave_sync
  import spi_fpga_slave_sync_pkg::*;
#(
  parameter int PACK_LENGTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic                   IN_CLK,
  input  logic                   IN_RESET,
  input  logic                   IN_CPOL,
  input  logic                   IN_CPHA,
  input  logic [PACK_LENGTH-1:0] IN_TRANSMIT_DATA,
  input  logic                   IN_TRANSMIT_VALID,
  output logic                   OUT_TRANSMIT_READY,
  input  logic                   SCLK,
  input  logic                   CS,
  input  logic                   MOSI,
  output logic                   MISO,
  output logic                   OUT_MISO_OE,
  output logic [PACK_LENGTH-1:0] OUT_RECEIVE_DATA,
  output logic                   OUT_DATA_READY,
  output logic                   OUT_TX_UNDERRUN,
  output logic                   OUT_FRAME_ERROR,
  output logic                   OUT_BUSY
);

  localparam int               CNT_W    = cnt_width(PACK_LENGTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PACK_LENGTH - 1);

  logic sclk_level, sclk_toggle, cs_level, cs_toggle;
  logic [SYNC_STAGES-1:0] mosi_sync_reg;
  logic mosi_bit, cs_fall, cs_rise;

  state_t    state_reg, state_next;
  spi_mode_t mode_reg, mode_next;
  logic [1:0] mode_bits;
  logic cpol_act, cpha_act, lead_edge, trail_edge, sample_edge, shift_edge;
  logic do_load, do_shift, do_sample, do_abort;

  logic [CNT_W-1:0]       cnt_reg;
  logic [PACK_LENGTH-1:0] tx_shift_reg, rx_shift_reg, hold_data_reg, rx_data_reg;
  logic [PACK_LENGTH-1:0] tx_shifted, rx_next;
  logic hold_full_reg, ready_reg, hold_write, full_next, tx_bit;
  logic data_ready_reg, underrun_reg, frame_error_reg;

  // CS idles high, so its synchroniser resets to 1 to avoid a false edge.
  spi_fpga_slave_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk(IN_CLK), .srst(IN_RESET), .din(SCLK), .level(sclk_level), .toggle(sclk_toggle)
  );
  spi_fpga_slave_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(IN_CLK), .srst(IN_RESET), .din(CS), .level(cs_level), .toggle(cs_toggle)
  );

  // MOSI needs no edge detect; same depth keeps it aligned with SCLK.
  always_ff @(posedge IN_CLK) begin
    if (IN_RESET) mosi_sync_reg <= '0;
    else          mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], MOSI};
  end

  assign mosi_bit = mosi_sync_reg[SYNC_STAGES-1];
  assign cs_fall  = cs_toggle & ~cs_level;
  assign cs_rise  = cs_toggle & cs_level;

  // Edge roles come from the mode latched at frame start, not the live inputs.
  assign mode_bits   = mode_reg;
  assign cpol_act    = mode_bits[MODE_CPOL_BIT];
  assign cpha_act    = mode_bits[MODE_CPHA_BIT];
  assign lead_edge   = sclk_toggle & (sclk_level != cpol_act);
  assign trail_edge  = sclk_toggle & (sclk_level == cpol_act);
  assign sample_edge = cpha_act ? trail_edge : lead_edge;
  assign shift_edge  = cpha_act ? lead_edge : trail_edge;

  // Bit-order dependent shift paths.
  generate
    if (MSB_FIRST) begin : g_msb
      assign tx_bit     = tx_shift_reg[PACK_LENGTH-1];
      assign tx_shifted = {tx_shift_reg[PACK_LENGTH-2:0], 1'b0};
      assign rx_next    = {rx_shift_reg[PACK_LENGTH-2:0], mosi_bit};
    end else begin : g_lsb
      assign tx_bit     = tx_shift_reg[0];
      assign tx_shifted = {1'b0, tx_shift_reg[PACK_LENGTH-1:1]};
      assign rx_next    = {mosi_bit, rx_shift_reg[PACK_LENGTH-1:1]};
    end
  endgenerate

  // Frame state and latched mode.
  always_ff @(posedge IN_CLK) begin
    if (IN_RESET) begin
      state_reg <= ST_IDLE;
      mode_reg  <= MODE_0;
    end else begin
      state_reg <= state_next;
      mode_reg  <= mode_next;
    end
  end

  // Next state and per-cycle datapath commands; SCLK ignored while idle.
  always_comb begin
    state_next = state_reg;
    mode_next  = mode_reg;
    do_load    = 1'b0;
    do_shift   = 1'b0;
    do_sample  = 1'b0;
    do_abort   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cs_fall) begin
          state_next = ST_ACTIVE;
          mode_next  = spi_mode_t'({IN_CPOL, IN_CPHA});
          do_load    = ~IN_CPHA;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise) begin
          state_next = ST_IDLE;
          do_abort   = 1'b1;
        end else begin
          do_sample = sample_edge;
          do_load   = shift_edge & (cnt_reg == '0);
          do_shift  = shift_edge & (cnt_reg != '0);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A write only happens while empty, so it never collides with a consume.
  assign hold_write = IN_TRANSMIT_VALID & ready_reg;
  assign full_next  = hold_write | (hold_full_reg & ~do_load);

  // Holding register, shift registers, bit counter and status pulses.
  always_ff @(posedge IN_CLK) begin
    if (IN_RESET) begin
      hold_data_reg   <= '0;
      hold_full_reg   <= 1'b0;
      ready_reg       <= 1'b0;
      tx_shift_reg    <= '0;
      rx_shift_reg    <= '0;
      rx_data_reg     <= '0;
      cnt_reg         <= '0;
      data_ready_reg  <= 1'b0;
      underrun_reg    <= 1'b0;
      frame_error_reg <= 1'b0;
    end else begin
      data_ready_reg  <= 1'b0;
      underrun_reg    <= 1'b0;
      frame_error_reg <= 1'b0;
      hold_full_reg   <= full_next;
      ready_reg       <= ~full_next;
      if (hold_write) hold_data_reg <= IN_TRANSMIT_DATA;
      if (do_load) begin
        tx_shift_reg <= hold_full_reg ? hold_data_reg : '0;
        underrun_reg <= ~hold_full_reg;
      end else if (do_shift) begin
        tx_shift_reg <= tx_shifted;
      end
      if (do_sample) begin
        rx_shift_reg <= rx_next;
        if (cnt_reg == LAST_BIT) begin
          cnt_reg        <= '0;
          rx_data_reg    <= rx_next;
          data_ready_reg <= 1'b1;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
      if (do_abort) begin
        cnt_reg         <= '0;
        rx_shift_reg    <= '0;
        frame_error_reg <= (cnt_reg != '0);
      end
    end
  end

  assign OUT_MISO_OE        = ~cs_level;
  assign MISO               = OUT_MISO_OE & tx_bit;
  assign OUT_TRANSMIT_READY = ready_reg;
  assign OUT_RECEIVE_DATA   = rx_data_reg;
  assign OUT_DATA_READY     = data_ready_reg;
  assign OUT_TX_UNDERRUN    = underrun_reg;
  assign OUT_FRAME_ERROR    = frame_error_reg;
  assign OUT_BUSY           = (state_reg == ST_ACTIVE);

endmodule
